// File: rtl/intt_core.sv
// intt_core: inverse NTT engine for the Dilithium ring (n = 256, q = 8380417).
// Loads 256 NTT-domain coefficients, runs 8 Gentleman-Sande stages at one
// butterfly per cycle, scales by 256^-1 mod q two coefficients per cycle,
// then streams 256 standard-domain coefficients out.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   in_valid_i/in_data_i     input coefficient stream (values < q)
//   in_ready_o               high in LOAD
//   out_valid_o/out_data_o   output coefficient stream (data 0 when not valid)
//   out_ready_i              downstream accept
//   busy_o                   high in BFLY and SCALE
//   tw_addr_o / tw_i         zeta ROM index out, standard-domain zeta back in
//
// state  | meaning
// LOAD   | accept 256 input coefficients into the array
// BFLY   | 8 stages x 128 butterflies, one per cycle
// SCALE  | multiply by N_INV, two coefficients per cycle, 128 cycles
// UNLOAD | stream 256 coefficients out under valid/ready
module intt_core (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  input  logic [23:0] in_data_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [23:0] out_data_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic [7:0]  tw_addr_o,
  input  logic [23:0] tw_i
);

  localparam logic [23:0] Q24     = 24'd8380417;
  localparam logic [47:0] Q48     = 48'd8380417;
  localparam logic [47:0] N_INV48 = 48'd8347681;

  typedef enum logic [1:0] {ST_LOAD, ST_BFLY, ST_SCALE, ST_UNLOAD} state_t;

  state_t      r_state;
  logic [7:0]  r_idx;
  logic [2:0]  r_stage;
  logic [6:0]  r_cnt;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_busy;
  logic [23:0] r_mem [256];

  logic        w_in_fire;
  logic        w_out_fire;
  logic [7:0]  w_len;
  logic [7:0]  w_g;
  logic [7:0]  w_j;
  logic [7:0]  w_jl;
  logic [23:0] w_x;
  logic [23:0] w_y;
  logic [23:0] w_sum;
  logic [23:0] w_add;
  logic [23:0] w_sub;
  logic [23:0] w_tw;
  logic [47:0] w_prod;
  logic [23:0] w_mul;
  logic [23:0] w_even;
  logic [23:0] w_odd;
  logic [23:0] w_even_sc;
  logic [23:0] w_odd_sc;

  assign w_in_fire  = in_valid_i && r_in_ready;
  assign w_out_fire = r_out_valid && out_ready_i;

  // Butterfly addressing: group g = b >> s, j = g*2len + (b mod len).
  // Bit s of j is always 0, so j+len is an OR.
  assign w_len = 8'd1 << r_stage;
  assign w_g   = {1'b0, r_cnt} >> r_stage;
  assign w_j   = (w_g << ({1'b0, r_stage} + 4'd1)) | ({1'b0, r_cnt} & (w_len - 8'd1));
  assign w_jl  = w_j | w_len;

  assign w_x = r_mem[w_j];
  assign w_y = r_mem[w_jl];

  // Both operands are < q and 2q < 2^24, so 24-bit sums cannot overflow.
  assign w_sum  = w_x + w_y;
  assign w_add  = (w_sum >= Q24) ? (w_sum - Q24) : w_sum;
  assign w_sub  = (w_x >= w_y) ? (w_x - w_y) : (w_x + (Q24 - w_y));
  assign w_tw   = Q24 - tw_i;
  assign w_prod = {24'd0, w_sub} * {24'd0, w_tw};
  assign w_mul  = 24'(w_prod % Q48);

  assign w_even    = r_mem[{r_cnt, 1'b0}];
  assign w_odd     = r_mem[{r_cnt, 1'b1}];
  assign w_even_sc = 24'(({24'd0, w_even} * N_INV48) % Q48);
  assign w_odd_sc  = 24'(({24'd0, w_odd} * N_INV48) % Q48);

  // (256 >> s) - 1 equals 255 >> s for every stage.
  assign tw_addr_o   = (r_state == ST_BFLY) ? ((8'hFF >> r_stage) - w_g) : 8'd0;
  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign busy_o      = r_busy;
  assign out_data_o  = r_out_valid ? r_mem[r_idx] : 24'd0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_LOAD;
      r_idx       <= 8'd0;
      r_stage     <= 3'd0;
      r_cnt       <= 7'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_in_fire) begin
            r_idx <= r_idx + 8'd1;
            if (r_idx == 8'd255) begin
              r_state    <= ST_BFLY;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end
        ST_BFLY: begin
          r_cnt <= r_cnt + 7'd1;
          if (r_cnt == 7'd127) begin
            r_stage <= r_stage + 3'd1;
            if (r_stage == 3'd7) r_state <= ST_SCALE;
          end
        end
        ST_SCALE: begin
          r_cnt <= r_cnt + 7'd1;
          if (r_cnt == 7'd127) begin
            r_state     <= ST_UNLOAD;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        ST_UNLOAD: begin
          if (w_out_fire) begin
            r_idx <= r_idx + 8'd1;
            if (r_idx == 8'd255) begin
              r_state     <= ST_LOAD;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= ST_LOAD;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Coefficient array has no reset; its contents are meaningless until loaded.
  always_ff @(posedge clk_i) begin
    case (r_state)
      ST_LOAD: begin
        if (w_in_fire) r_mem[r_idx] <= in_data_i;
      end
      ST_BFLY: begin
        r_mem[w_j]  <= w_add;
        r_mem[w_jl] <= w_mul;
      end
      ST_SCALE: begin
        r_mem[{r_cnt, 1'b0}] <= w_even_sc;
        r_mem[{r_cnt, 1'b1}] <= w_odd_sc;
      end
      default: ;
    endcase
  end

endmodule
